// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared constants and types for the VGA output pipeline:
//                PMOD bit positions, pipeline latency, 2:2:2 colour struct
//                and a helper that packs colour plus syncs onto the PMOD bus.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int PIPE_LATENCY = 3;

  // Tiny VGA PMOD bus bit positions
  localparam int PMOD_R1 = 0;
  localparam int PMOD_G1 = 1;
  localparam int PMOD_B1 = 2;
  localparam int PMOD_VS = 3;
  localparam int PMOD_R0 = 4;
  localparam int PMOD_G0 = 5;
  localparam int PMOD_B0 = 6;
  localparam int PMOD_HS = 7;

  // Blank colour with both syncs inactive (high)
  localparam logic [7:0] PMOD_IDLE = 8'h88;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } rgb222_t;

  function automatic logic [7:0] pmod_pack(input rgb222_t c, input logic hs, input logic vs);
    logic [7:0] bus;
    bus          = '0;
    bus[PMOD_R1] = c.r[1];
    bus[PMOD_G1] = c.g[1];
    bus[PMOD_B1] = c.b[1];
    bus[PMOD_VS] = vs;
    bus[PMOD_R0] = c.r[0];
    bus[PMOD_G0] = c.g[0];
    bus[PMOD_B0] = c.b[0];
    bus[PMOD_HS] = hs;
    return bus;
  endfunction

endpackage
`default_nettype wire

// File: rtl/en_delay.sv
`default_nettype none
// ============================================================================
//  Module      : en_delay
//  Description : Enable-gated shift register of DEPTH stages. Stages move
//                only when en=1 and load RESET_VAL on synchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module en_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Shift by one stage on enable, otherwise every stage holds
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i];
    end
    if (en) begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  generate
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      // Stage register; reset wins over enable
      always_ff @(posedge clk) begin
        if (reset) stage_q[s] <= RESET_VAL;
        else       stage_q[s] <= stage_d[s];
      end
    end
  endgenerate

  assign dout = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_out_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : vga_out_pipe
//  Description : Three-stage enable-gated VGA output pipe. S1 captures the
//                scanner position/syncs and the frame count, S2 forms the
//                XOR+frame pattern, S3 drives the PMOD bus. Syncs, active
//                and the valid bit travel alongside in an en_delay line so
//                every field of the bus has the same latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_out_pipe
  import vga_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic signed [10:0]    x,
  input  logic signed [9:0]     y,
  input  logic                  active,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  new_frame,
  output logic [7:0]            uo_out,
  output logic [FRAME_BITS-1:0] frame
);

  // Sideband word: {valid, active, hsync, vsync}; syncs idle high
  localparam int               SIDE_W     = 4;
  localparam logic [SIDE_W-1:0] SIDE_RESET = 4'b0011;

  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [5:0]            xs_q, xs_d;     // S1: x[8:3]
  logic [5:0]            ys_q, ys_d;     // S1: y[7:2]
  logic [5:0]            fs_q, fs_d;     // S1: frame[5:0] at capture time
  logic [5:0]            p_q, p_d;       // S2: pattern
  logic [7:0]            uo_q, uo_d;     // S3: PMOD bus

  logic [SIDE_W-1:0]     side_s2;
  logic                  valid_s2, active_s2, hsync_s2, vsync_s2;
  rgb222_t               colour;

  // Only these slices of the position feed the pattern
  logic unused_pos_bits;
  assign unused_pos_bits = ^{x[10:9], x[2:0], y[9:8], y[1:0]};

  // Valid/active/sync delayed to line up with the S2 pattern register
  en_delay #(
    .WIDTH     (SIDE_W),
    .DEPTH     (PIPE_LATENCY - 1),
    .RESET_VAL (SIDE_RESET)
  ) u_side_delay (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .din   ({1'b1, active, hsync, vsync}),
    .dout  (side_s2)
  );

  assign {valid_s2, active_s2, hsync_s2, vsync_s2} = side_s2;

  // Next-state for frame counter and all three stages; hold when en=0
  always_comb begin
    frame_d = frame_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    fs_d    = fs_q;
    p_d     = p_q;
    uo_d    = uo_q;
    colour  = '0;
    if (valid_s2 && active_s2) begin
      colour = rgb222_t'(p_q);
    end
    if (en) begin
      if (new_frame) begin
        frame_d = frame_q + FRAME_BITS'(1);
      end
      xs_d = x[8:3];
      ys_d = y[7:2];
      fs_d = frame_q[5:0];
      p_d  = (xs_q ^ ys_q) + fs_q;
      uo_d = pmod_pack(colour,
                       valid_s2 ? hsync_s2 : 1'b1,
                       valid_s2 ? vsync_s2 : 1'b1);
    end
  end

  // Pipeline and frame registers; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      xs_q    <= '0;
      ys_q    <= '0;
      fs_q    <= '0;
      p_q     <= '0;
      uo_q    <= PMOD_IDLE;
    end else begin
      frame_q <= frame_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      fs_q    <= fs_d;
      p_q     <= p_d;
      uo_q    <= uo_d;
    end
  end

  assign uo_out = uo_q;
  assign frame  = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_out_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_out_pipe
//  Description : Directed self-checking bench for vga_out_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_out_pipe;

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic signed [10:0] x;
  logic signed [9:0]  y;
  logic               active;
  logic               hsync;
  logic               vsync;
  logic               new_frame;
  logic [7:0]         uo_out;
  logic [7:0]         frame;

  int checks = 0;
  int errors = 0;

  vga_out_pipe #(.FRAME_BITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .x         (x),
    .y         (y),
    .active    (active),
    .hsync     (hsync),
    .vsync     (vsync),
    .new_frame (new_frame),
    .uo_out    (uo_out),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [10:0] xi, input logic [9:0] yi,
                     input logic a, input logic h, input logic v);
    x      = xi;
    y      = yi;
    active = a;
    hsync  = h;
    vsync  = v;
  endtask

  // Vectors (frame=0): A->CC, B->88, C->4C, D->C0, E->FF, F->88, G->89
  task automatic vec(input int id);
    case (id)
      0: put(11'd16,  10'd4,   1'b1, 1'b1, 1'b1);
      1: put(11'd16,  10'd4,   1'b0, 1'b1, 1'b1);
      2: put(11'd16,  10'd4,   1'b1, 1'b0, 1'b1);
      3: put(11'd8,   10'd0,   1'b1, 1'b1, 1'b0);
      4: put(11'd504, 10'd0,   1'b1, 1'b1, 1'b1);
      5: put(11'h7F8, 10'd252, 1'b1, 1'b1, 1'b1);
      default: put(11'd256, 10'd0, 1'b1, 1'b1, 1'b1);
    endcase
  endtask

  task automatic step(input logic e, input logic nf);
    en        = e;
    new_frame = nf;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    new_frame = 1'b0;
    vec(0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_uo", uo_out, 8'h88);
    chk("reset_frame", frame, 8'd0);

    // Continuous stream A..G then hold G
    reset = 1'b0;
    vec(0); step(1'b1, 1'b0); chk("lat_e1", uo_out, 8'h88);
    vec(1); step(1'b1, 1'b0); chk("lat_e2", uo_out, 8'h88);
    vec(2); step(1'b1, 1'b0); chk("A_cc", uo_out, 8'hCC);
    vec(3); step(1'b1, 1'b0); chk("B_inactive", uo_out, 8'h88);
    vec(4); step(1'b1, 1'b0); chk("C_hsync0", uo_out, 8'h4C);
    vec(5); step(1'b1, 1'b0); chk("D_vsync0", uo_out, 8'hC0);
    vec(6); step(1'b1, 1'b0); chk("E_white", uo_out, 8'hFF);
    step(1'b1, 1'b0); chk("F_zero_pat", uo_out, 8'h88);
    step(1'b1, 1'b0); chk("G_red1", uo_out, 8'h89);

    // Enable pattern 1,0,0,1,1 with junk inputs while disabled
    vec(0); step(1'b1, 1'b0); chk("en_a", uo_out, 8'h89);
    vec(4); step(1'b0, 1'b1); chk("en_hold1", uo_out, 8'h89);
    chk("en_hold_frame", frame, 8'd0);
    vec(5); step(1'b0, 1'b0); chk("en_hold2", uo_out, 8'h89);
    vec(3); step(1'b1, 1'b0); chk("en_d", uo_out, 8'h89);
    vec(2); step(1'b1, 1'b0); chk("en_e_A", uo_out, 8'hCC);
    vec(1); step(1'b1, 1'b0); chk("en_f_D", uo_out, 8'hC0);
    step(1'b1, 1'b0); chk("en_g_C", uo_out, 8'h4C);
    step(1'b1, 1'b0); chk("en_h_B", uo_out, 8'h88);

    // Frame feeds the pattern at the value held when S1 captures
    step(1'b1, 1'b1); chk("frame_1", frame, 8'd1);
    vec(0); step(1'b1, 1'b1); chk("frame_2", frame, 8'd2);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("A_frame1", uo_out, 8'hA8);
    step(1'b1, 1'b0); chk("A_frame2", uo_out, 8'hE8);

    // Count to 255 and wrap
    for (int f = 3; f <= 255; f++) begin
      step(1'b1, 1'b1);
      chk("frame_count", frame, 8'(f));
    end
    step(1'b1, 1'b1); chk("frame_wrap", frame, 8'd0);
    step(1'b0, 1'b1); chk("frame_en0", frame, 8'd0);
    step(1'b1, 1'b1); chk("frame_pre_rst", frame, 8'd1);
    reset = 1'b1;
    step(1'b1, 1'b1); chk("frame_rst_wins", frame, 8'd0);
    chk("rst_uo", uo_out, 8'h88);

    // Mid-line reset with pixels in flight, en low during reset
    reset = 1'b0;
    vec(0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0); chk("pre_midrst", uo_out, 8'hCC);
    reset = 1'b1;
    step(1'b0, 1'b0); chk("midrst_uo", uo_out, 8'h88);
    reset = 1'b0;
    step(1'b1, 1'b0); chk("post_rst_e1", uo_out, 8'h88);
    step(1'b1, 1'b0); chk("post_rst_e2", uo_out, 8'h88);
    step(1'b1, 1'b0); chk("post_rst_e3", uo_out, 8'hCC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_out_pipe.md
VGA_OUT_PIPE -- requirements
Module: vga_out_pipe

Interface
REQ-001 Parameter: FRAME_BITS, 8, width of the internal frame counter (minimum 6).
REQ-002 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-003 Port: reset  in  1  reset, synchronous, active-high.
REQ-004 Port: en  in  1  pixel-clock enable; the same enable that advances the raster scanner.
REQ-005 Port: x  in  11 signed  horizontal position from the scanner (two counts per pixel).
REQ-006 Port: y  in  10 signed  vertical position from the scanner.
REQ-007 Port: active  in  1  high inside the visible region.
REQ-008 Port: hsync  in  1  horizontal sync, active-low.
REQ-009 Port: vsync  in  1  vertical sync, active-low.
REQ-010 Port: new_frame  in  1  one-cycle pulse at end of frame (qualified by en).
REQ-011 Port: uo_out  out  8  VGA PMOD bus: [0]R1 [1]G1 [2]B1 [3]VS [4]R0 [5]G0 [6]B0 [7]HS.
REQ-012 Port: frame  out  FRAME_BITS  current frame count.

Function
REQ-013 Pipeline SHALL be 3 stages (S1 capture, S2 pattern, S3 output), each advancing only on cycles with en=1.
REQ-014 With en=0, every pipeline register, the frame counter and uo_out SHALL hold their value.
REQ-015 Latency SHALL be exactly 3 en-qualified cycles from inputs to uo_out, identical for sync, active and colour.
REQ-016 S1 SHALL register x, y, active, hsync, vsync; frame SHALL increment by 1 when en && new_frame, wrapping from 2^FRAME_BITS-1 to 0.
REQ-017 S2 SHALL compute the 6-bit value p = (x[8:3] XOR y[7:2]) + frame[5:0], modulo 64, using the S1 register values; frame is sampled in the same cycle S1 captures.
REQ-018 S3 SHALL drive r=p[5:4], g=p[3:2], b=p[1:0] when delayed active=1 and the pipe is valid; otherwise r=g=b=0.
REQ-019 S3 SHALL drive HS and VS from the 3-stage-delayed hsync/vsync, polarity unchanged.
REQ-020 The pipe SHALL carry a valid bit per stage; until 3 en-cycles have elapsed after reset, uo_out SHALL show blank colour with HS=VS=1.
REQ-021 If reset and en && new_frame coincide, reset SHALL win and frame SHALL be 0.
REQ-022 Colour SHALL be 0 in every cycle whose delayed active=0, including the first and last pixel edges of a line.

Reset
REQ-023 On reset: uo_out=8'h88 (HS=VS=1, colour 0), frame=0, all valid bits 0, all data registers 0 and sync registers 1.
REQ-024 A reset asserted mid-line SHALL take effect on the next clock edge regardless of en, discarding all in-flight pixels.

Structure
REQ-025 A shared package vga_pkg SHALL hold the PMOD bit-index constants, PIPE_LATENCY=3 and the rgb222 struct typedef.
REQ-026 One sub-module, en_delay (parameters WIDTH, DEPTH, RESET_VAL), SHALL implement the enable-gated delay line for sync, active and valid.

Verification
REQ-027 After reset with en=1 for 2 cycles -> uo_out=8'h88; on cycle 3 -> uo_out reflects the first captured input.
REQ-028 x=16, y=4, frame=0, active=1, hsync=vsync=1 -> 3 en-cycles later uo_out=8'hCC.
REQ-029 Same inputs with active=0 -> uo_out=8'h88; with hsync=0 -> uo_out[7]=0 with timing identical to colour.
REQ-030 Toggle en 1,0,0,1,1 with a changing input stream -> the output sequence equals the en=1 reference sequence with holds inserted; no sample is lost or duplicated.
REQ-031 Issue 256 new_frame pulses -> frame counts 0..255 and then wraps to 0; a pulse with en=0 is ignored; a pulse coincident with reset -> frame=0.
REQ-032 Assert reset mid-line with valid pixels in flight -> next cycle uo_out=8'h88, and blanking lasts 3 en-cycles.
